// File: rtl/forwarding_engine_if.sv
// Buffer-to-engine bus: per-port frame status, grant pulses, the 128-bit beat stream,
// port configuration and per-port egress write strobes.
interface forwarding_engine_if #(
  parameter int NUM_PORTS = 15
);
  logic [NUM_PORTS*24-1:0] fabric_state;
  logic [NUM_PORTS-1:0]    forward_en;
  logic                    frame_valid;
  logic                    frame_last;
  logic [127:0]            frame_data;
  logic [NUM_PORTS*12-1:0] port_vlan;
  logic [NUM_PORTS-1:0]    port_trunk;
  logic [NUM_PORTS-1:0]    port_space_avail;
  logic [NUM_PORTS-1:0]    frame_port_wr;
  logic [10:0]             frame_len;

  modport master (
    output fabric_state, frame_valid, frame_last, frame_data,
           port_vlan, port_trunk, port_space_avail,
    input  forward_en, frame_port_wr, frame_len
  );

  modport slave (
    input  fabric_state, frame_valid, frame_last, frame_data,
           port_vlan, port_trunk, port_space_avail,
    output forward_en, frame_port_wr, frame_len
  );
endinterface

// File: rtl/forwarding_engine.sv
// Per-frame forwarding decision: round-robin picks a ready ingress port, grants it,
// and strobes the VLAN/space-qualified egress mask on every beat of the frame.
module forwarding_engine #(
  parameter int NUM_PORTS = 15
) (
  input logic                 clk_ram_ctl,
  input logic                 rst,
  forwarding_engine_if.slave  bus
);
  localparam int PW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

  state_t               state, state_nxt;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        src;
  logic [10:0]          len;
  logic [10:0]          cur_len;
  logic [NUM_PORTS-1:0] dest_mask;

  logic [NUM_PORTS-1:0] ready;
  logic [11:0]          ready_vlan [NUM_PORTS];
  logic [10:0]          ready_len  [NUM_PORTS];
  logic                 sel_found;
  logic [PW-1:0]        sel_src;
  logic [11:0]          sel_vlan;
  logic [10:0]          sel_len;
  logic [NUM_PORTS-1:0] sel_mask;
  logic                 frame_end;

  // Beat payload goes straight to the egress FIFOs; only its presence matters here.
  logic unused_data;
  assign unused_data = ^bus.frame_data;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign ready[p]      = bus.fabric_state[24*p+23];
    assign ready_vlan[p] = bus.fabric_state[24*p+11 +: 12];
    assign ready_len[p]  = bus.fabric_state[24*p +: 11];
    // A trunk is a member of every VLAN; the source never receives its own frame.
    assign sel_mask[p]   = (bus.port_trunk[p] | (bus.port_vlan[12*p +: 12] == sel_vlan))
                         & (sel_src != PW'(p)) & bus.port_space_avail[p];
    assign bus.forward_en[p] = (state == GRANT) && (src == PW'(p));
  end

  always_comb begin : rr_select
    int            idx;
    logic [PW-1:0] cand;
    sel_found = 1'b0;
    sel_src   = '0;
    idx       = 0;
    cand      = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      cand = PW'(idx);
      if (!sel_found && ready[cand]) begin
        sel_found = 1'b1;
        sel_src   = cand;
      end
    end
  end

  assign sel_vlan  = ready_vlan[sel_src];
  assign sel_len   = ready_len[sel_src];
  assign frame_end = (state == BUSY) && bus.frame_valid && bus.frame_last;

  always_ff @(posedge clk_ram_ctl) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = GRANT;
      GRANT:   state_nxt = BUSY;
      BUSY:    if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_ram_ctl) begin
    if (rst) begin
      rr_ptr  <= PW'(NUM_PORTS - 1);
      cur_len <= '0;
    end else begin
      if (state == GRANT) cur_len <= len;
      if (frame_end)      rr_ptr  <= src;
    end
  end

  // Decision registers; space is sampled only here, so mid-frame changes are ignored.
  always_ff @(posedge clk_ram_ctl) begin
    if (state == IDLE && sel_found) begin
      src       <= sel_src;
      len       <= sel_len;
      dest_mask <= sel_mask;
    end
  end

  assign bus.frame_port_wr = (state == BUSY && bus.frame_valid) ? dest_mask : '0;
  assign bus.frame_len     = cur_len;
endmodule

// File: tb/tb_forwarding_engine.sv
// Directed, table-driven bench for forwarding_engine: grants, round-robin order,
// egress masks, drop, single-beat frames and reset mid-frame.
module tb_forwarding_engine;
  localparam int NP = 15;

  typedef struct {
    logic [NP-1:0] ready;
    logic [NP-1:0] space;
    logic [11:0]   vlan;
    logic [10:0]   len;
    logic [NP-1:0] exp_fwd;
    logic [NP-1:0] exp_mask;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs [8];
  vec_t v_rst, v_after;

  forwarding_engine_if #(.NUM_PORTS(NP)) bus ();

  forwarding_engine #(.NUM_PORTS(NP)) dut (
    .clk_ram_ctl (clk),
    .rst         (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ready(input logic [NP-1:0] mask, input logic [11:0] vlan, input logic [10:0] len);
    for (int p = 0; p < NP; p++)
      bus.fabric_state[24*p +: 24] = mask[p] ? {1'b1, vlan, len} : 24'd0;
  endtask

  // Runs one frame; rst_beat >= 0 asserts rst alongside that beat.
  task automatic run_frame(input vec_t v, input int rst_beat);
    int   waited;
    int   beats;
    logic aborted;
    aborted = 1'b0;
    bus.port_space_avail = v.space;
    set_ready(v.ready, v.vlan, v.len);
    waited = 0;
    do begin
      @(negedge clk); #1;
      waited++;
    end while (bus.forward_en == '0 && waited < 8);
    check("grant", 32'(bus.forward_en), 32'(v.exp_fwd));
    if (bus.forward_en == '0) begin
      set_ready('0, 12'd0, 11'd0);
      return;
    end
    check("grant_latency", 32'(waited), 32'd1);
    check("wr_in_grant", 32'(bus.frame_port_wr), 32'd0);
    for (int p = 0; p < NP; p++)
      if (v.exp_fwd[p]) bus.fabric_state[24*p+23] = 1'b0;
    bus.port_space_avail = '0;
    @(negedge clk); #1;
    check("grant_pulse_end", 32'(bus.forward_en), 32'd0);
    check("frame_len", 32'(bus.frame_len), 32'(v.len));
    beats = (int'(v.len) + 15) / 16;
    for (int b = 0; b < beats; b++) begin
      if (b == 1) begin
        bus.frame_valid = 1'b0;
        #1 check("bubble_wr", 32'(bus.frame_port_wr), 32'd0);
        @(negedge clk); #1;
      end
      bus.frame_valid = 1'b1;
      bus.frame_last  = (b == beats - 1);
      bus.frame_data  = {$urandom, $urandom, $urandom, $urandom};
      if (b == rst_beat) rst = 1'b1;
      #1;
      check($sformatf("beat%0d_wr", b), 32'(bus.frame_port_wr), aborted ? 32'd0 : 32'(v.exp_mask));
      check($sformatf("beat%0d_len", b), 32'(bus.frame_len), aborted ? 32'd0 : 32'(v.len));
      check($sformatf("beat%0d_fwd", b), 32'(bus.forward_en), 32'd0);
      @(negedge clk); #1;
      if (b == rst_beat) begin
        rst = 1'b0;
        aborted = 1'b1;
      end
    end
    bus.frame_valid = 1'b0;
    bus.frame_last  = 1'b0;
    #1;
    check("idle_wr", 32'(bus.frame_port_wr), 32'd0);
    check("idle_fwd", 32'(bus.forward_en), 32'd0);
    check("len_hold", 32'(bus.frame_len), aborted ? 32'd0 : 32'(v.len));
  endtask

  initial begin
    //                ready      space      vlan    len       fwd        mask
    vecs[0] = '{15'h0008, 15'h7FFF, 12'd5, 11'd68,   15'h0008, 15'h4001};
    vecs[1] = '{15'h0010, 15'h7FFF, 12'd6, 11'd1066, 15'h0010, 15'h4001};
    vecs[2] = '{15'h0018, 15'h7FFF, 12'd5, 11'd68,   15'h0008, 15'h4001};
    vecs[3] = '{15'h0018, 15'h7FFF, 12'd5, 11'd68,   15'h0010, 15'h4001};
    vecs[4] = '{15'h0018, 15'h7FFF, 12'd5, 11'd68,   15'h0008, 15'h4001};
    vecs[5] = '{15'h0008, 15'h3FFF, 12'd4, 11'd68,   15'h0008, 15'h0001};
    vecs[6] = '{15'h0001, 15'h0000, 12'd9, 11'd68,   15'h0001, 15'h0000};
    vecs[7] = '{15'h0040, 15'h7FFF, 12'd1, 11'd16,   15'h0040, 15'h7FA7};
    v_rst   = '{15'h0008, 15'h7FFF, 12'd5, 11'd68,   15'h0008, 15'h4001};
    v_after = '{15'h0020, 15'h7FFF, 12'd1, 11'd60,   15'h0020, 15'h7FC7};

    bus.port_trunk       = 15'h4001;
    bus.port_space_avail = 15'h7FFF;
    for (int p = 0; p < NP; p++)
      bus.port_vlan[12*p +: 12] = (p == 3) ? 12'd4 : (p == 4) ? 12'd6 : 12'd1;
    bus.fabric_state = '0;
    bus.frame_valid  = 1'b0;
    bus.frame_last   = 1'b0;
    bus.frame_data   = '0;

    repeat (3) @(negedge clk);
    #1;
    check("reset_fwd", 32'(bus.forward_en), 32'd0);
    check("reset_wr", 32'(bus.frame_port_wr), 32'd0);
    check("reset_len", 32'(bus.frame_len), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // A beat with nothing granted must not strobe any port.
    bus.frame_valid = 1'b1;
    bus.frame_last  = 1'b1;
    #1 check("stray_beat_wr", 32'(bus.frame_port_wr), 32'd0);
    @(negedge clk); #1;
    bus.frame_valid = 1'b0;
    bus.frame_last  = 1'b0;

    for (int i = 0; i < 8; i++) run_frame(vecs[i], -1);

    run_frame(v_rst, 2);
    run_frame(v_after, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
